// File: rtl/store_buffer_ctrl.sv
// Store buffer between execute_lsu, commit and the data bus: holds speculative stores,
// drains committed ones in order, and forwards or stalls loads that hit buffered stores.
module store_buffer_ctrl #(
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 7,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    exlsu_stbuf_push,
  input  logic [ROB_ID_WIDTH-1:0] exlsu_stbuf_rob_id,
  input  logic [ADDR_WIDTH-1:0]   exlsu_stbuf_write_addr,
  input  logic [1:0]              exlsu_stbuf_write_size,
  input  logic [DATA_WIDTH-1:0]   exlsu_stbuf_write_data,
  output logic                    stbuf_exlsu_full,
  input  logic                    exlsu_stbuf_read_req,
  input  logic [ADDR_WIDTH-1:0]   exlsu_stbuf_read_addr,
  input  logic [1:0]              exlsu_stbuf_read_size,
  output logic                    stbuf_exlsu_bus_ready,
  output logic [DATA_WIDTH-1:0]   stbuf_exlsu_bus_data_feedback,
  input  logic                    commit_stbuf_valid,
  input  logic [ROB_ID_WIDTH-1:0] commit_stbuf_rob_id,
  input  logic                    commit_stbuf_flush,
  output logic [ADDR_WIDTH-1:0]   stbuf_bus_addr,
  output logic [1:0]              stbuf_bus_size,
  output logic [DATA_WIDTH-1:0]   stbuf_bus_write_data,
  output logic                    stbuf_bus_we,
  output logic                    stbuf_bus_re,
  input  logic                    bus_stbuf_ready,
  input  logic [DATA_WIDTH-1:0]   bus_stbuf_read_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                  state, state_next;
  logic [ROB_ID_WIDTH-1:0] rob_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_mem [DEPTH];
  logic [1:0]              size_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem [DEPTH];

  // Committed entries always form a prefix of the valid region, so the commit
  // pointer is head + ccount and per-entry valid/committed flags are implied.
  logic [PW-1:0] head, tail, cmt_ptr, head_next, tail_next;
  logic [CW-1:0] count, ccount, count_next, ccount_next;
  logic [SW-1:0] starve_cnt;

  logic commit_ok, push_ok, grant, head_committed;
  logic hit_any, young_exact, overlap, forward, stall, want_read;
  logic [1:0]            young_size;
  logic [DATA_WIDTH-1:0] young_data, lane_data;
  logic [PW-1:0]         idx;
  logic [3:0]            ld_mask;

  function automatic logic [3:0] byte_mask(input logic [1:0] offset, input logic [1:0] size);
    logic [3:0] base;
    case (size)
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << offset;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return DATA_WIDTH'(8'hFF);
      2'b01:   return DATA_WIDTH'(16'hFFFF);
      default: return '1;
    endcase
  endfunction

  assign stbuf_exlsu_full = (count == CW'(DEPTH));
  assign cmt_ptr          = head + ccount[PW-1:0];
  assign head_committed   = (ccount != '0);
  assign commit_ok        = commit_stbuf_valid && (count != ccount) &&
                            (rob_mem[cmt_ptr] == commit_stbuf_rob_id);
  assign push_ok          = exlsu_stbuf_push && !stbuf_exlsu_full && !commit_stbuf_flush;

  // Youngest same-word entry wins: the scan runs oldest to youngest and later hits overwrite.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    hit_any     = 1'b0;
    young_exact = 1'b0;
    overlap     = 1'b0;
    young_size  = '0;
    young_data  = '0;
    idx         = '0;
    ld_mask     = byte_mask(exlsu_stbuf_read_addr[1:0], exlsu_stbuf_read_size);
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) &&
          (addr_mem[idx][ADDR_WIDTH-1:2] == exlsu_stbuf_read_addr[ADDR_WIDTH-1:2])) begin
        hit_any     = 1'b1;
        young_exact = (addr_mem[idx] == exlsu_stbuf_read_addr);
        young_size  = size_mem[idx];
        young_data  = data_mem[idx];
        if ((byte_mask(addr_mem[idx][1:0], size_mem[idx]) & ld_mask) != 4'b0000)
          overlap = 1'b1;
      end
    end
  end

  assign forward   = exlsu_stbuf_read_req && hit_any && young_exact &&
                     (young_size >= exlsu_stbuf_read_size);
  assign stall     = exlsu_stbuf_read_req && !forward && overlap;
  assign want_read = exlsu_stbuf_read_req && !forward && !stall;

  // A pending drain loses to a load read until it has starved STARVE_LIMIT cycles.
  assign stbuf_bus_we = (state == WRITE) && ((starve_cnt == SW'(STARVE_LIMIT)) || !want_read);
  assign stbuf_bus_re = want_read && !stbuf_bus_we;
  assign grant        = stbuf_bus_we && bus_stbuf_ready;

  assign lane_data = (bus_stbuf_read_data >> {exlsu_stbuf_read_addr[1:0], 3'b000}) &
                     size_mask(exlsu_stbuf_read_size);

  assign stbuf_exlsu_bus_ready = forward || (stbuf_bus_re && bus_stbuf_ready);
  assign stbuf_exlsu_bus_data_feedback =
      forward ? (young_data & size_mask(exlsu_stbuf_read_size)) :
      (stbuf_bus_re && bus_stbuf_ready) ? lane_data : '0;

  assign stbuf_bus_addr       = stbuf_bus_we ? addr_mem[head] :
                                stbuf_bus_re ? exlsu_stbuf_read_addr : '0;
  assign stbuf_bus_size       = stbuf_bus_we ? size_mem[head] :
                                stbuf_bus_re ? exlsu_stbuf_read_size : '0;
  assign stbuf_bus_write_data = stbuf_bus_we ? data_mem[head] : '0;

  // Commit, then flush, then push; a drain pop can coincide with any of them.
  always_comb begin
    head_next   = head + PW'(grant);
    ccount_next = ccount + CW'(commit_ok) - CW'(grant);
    if (commit_stbuf_flush) begin
      tail_next  = head_next + ccount_next[PW-1:0];
      count_next = ccount_next;
    end else begin
      tail_next  = tail + PW'(push_ok);
      count_next = count + CW'(push_ok) - CW'(grant);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (head_committed) state_next = WRITE;
      WRITE:   if (grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ccount     <= '0;
      starve_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state  <= state_next;
      head   <= head_next;
      tail   <= tail_next;
      count  <= count_next;
      ccount <= ccount_next;
      if (grant)
        starve_cnt <= '0;
      else if ((state == WRITE) && !stbuf_bus_we && (starve_cnt != SW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // NOTE: entry storage is not reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      rob_mem[tail]  <= exlsu_stbuf_rob_id;
      addr_mem[tail] <= exlsu_stbuf_write_addr;
      size_mem[tail] <= exlsu_stbuf_write_size;
      data_mem[tail] <= exlsu_stbuf_write_data;
    end
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Randomized and directed bench for store_buffer_ctrl against a queue-based reference model.
module tb_store_buffer_ctrl;

  localparam int DEPTH        = 16;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [6:0]  push_rob;
  logic [31:0] write_addr;
  logic [1:0]  write_size;
  logic [31:0] write_data;
  logic        full;
  logic        read_req;
  logic [31:0] read_addr;
  logic [1:0]  read_size;
  logic        ld_ready;
  logic [31:0] feedback;
  logic        commit_valid;
  logic [6:0]  commit_rob;
  logic        flush;
  logic [31:0] bus_addr;
  logic [1:0]  bus_size;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  store_buffer_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .exlsu_stbuf_push              (push),
    .exlsu_stbuf_rob_id            (push_rob),
    .exlsu_stbuf_write_addr        (write_addr),
    .exlsu_stbuf_write_size        (write_size),
    .exlsu_stbuf_write_data        (write_data),
    .stbuf_exlsu_full              (full),
    .exlsu_stbuf_read_req          (read_req),
    .exlsu_stbuf_read_addr         (read_addr),
    .exlsu_stbuf_read_size         (read_size),
    .stbuf_exlsu_bus_ready         (ld_ready),
    .stbuf_exlsu_bus_data_feedback (feedback),
    .commit_stbuf_valid            (commit_valid),
    .commit_stbuf_rob_id           (commit_rob),
    .commit_stbuf_flush            (flush),
    .stbuf_bus_addr                (bus_addr),
    .stbuf_bus_size                (bus_size),
    .stbuf_bus_write_data          (bus_wdata),
    .stbuf_bus_we                  (bus_we),
    .stbuf_bus_re                  (bus_re),
    .bus_stbuf_ready               (bus_ready),
    .bus_stbuf_read_data           (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  rob;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    bit          committed;
  } entry_t;

  entry_t sb[$];
  bit     writing;
  int     starve;
  int     vectors;
  int     miscompares;
  logic [6:0] rob_ctr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] lmask(input logic [1:0] s);
    return (s == 2'd0) ? 32'hFF : (s == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_inputs();
    push = 0; push_rob = '0; write_addr = '0; write_size = '0; write_data = '0;
    read_req = 0; read_addr = '0; read_size = '0;
    commit_valid = 0; commit_rob = '0; flush = 0;
    bus_ready = 0; bus_rdata = '0;
  endtask

  task automatic reset_model();
    sb.delete();
    writing = 0;
    starve  = 0;
  endtask

  // Inputs are already driven just after a negedge; check, advance the model, move on.
  task automatic cycle();
    bit fwd, stall, ov, want, ewe, ere, erdy, grant, full_now, next_writing;
    logic [31:0] fdata, efb;
    longint la, sa;
    int y, ci;
    entry_t e;
    #1;
    full_now = (sb.size() == DEPTH);
    fwd = 0; stall = 0; ov = 0; fdata = '0; y = -1;
    if (read_req) begin
      foreach (sb[i]) begin
        if ((sb[i].addr >> 2) == (read_addr >> 2)) begin
          y  = i;
          la = read_addr;
          sa = sb[i].addr;
          if (sa < la + nbytes(read_size) && la < sa + nbytes(sb[i].size)) ov = 1;
        end
      end
      if (y >= 0 && sb[y].addr == read_addr && sb[y].size >= read_size) begin
        fwd   = 1;
        fdata = sb[y].data & lmask(read_size);
      end else begin
        stall = ov;
      end
    end
    want = read_req && !fwd && !stall;
    ewe  = writing && (starve == STARVE_LIMIT || !want);
    ere  = want && !ewe;
    erdy = fwd || (ere && bus_ready);
    efb  = fwd ? fdata : ((bus_rdata >> (8 * int'(read_addr[1:0]))) & lmask(read_size));

    check("full", full, full_now);
    check("bus_we", bus_we, ewe);
    check("bus_re", bus_re, ere);
    check("ld_ready", ld_ready, erdy);
    if (ewe && sb.size() > 0) begin
      check("wr_addr", bus_addr, sb[0].addr);
      check("wr_size", bus_size, sb[0].size);
      check("wr_data", bus_wdata, sb[0].data);
    end
    if (ere) begin
      check("rd_addr", bus_addr, read_addr);
      check("rd_size", bus_size, read_size);
    end
    if (erdy) check("feedback", feedback, efb);

    grant        = ewe && bus_ready;
    next_writing = writing ? !grant : (sb.size() > 0 && sb[0].committed);
    if (grant) starve = 0;
    else if (writing && !ewe && starve < STARVE_LIMIT) starve++;
    ci = 0;
    while (ci < sb.size() && sb[ci].committed) ci++;
    if (commit_valid && ci < sb.size() && sb[ci].rob == commit_rob) begin
      e = sb[ci];
      e.committed = 1;
      sb[ci] = e;
    end
    if (grant) void'(sb.pop_front());
    if (flush) while (sb.size() > 0 && !sb[sb.size()-1].committed) void'(sb.pop_back());
    if (push && !full_now && !flush) begin
      e.rob = push_rob; e.addr = write_addr; e.size = write_size; e.data = write_data;
      e.committed = 0;
      sb.push_back(e);
    end
    writing = next_writing;
    @(negedge clk);
  endtask

  task automatic drive_push(input logic [6:0] rob, input logic [31:0] a,
                            input logic [1:0] s, input logic [31:0] d);
    push = 1; push_rob = rob; write_addr = a; write_size = s; write_data = d;
  endtask

  function automatic logic [31:0] rand_addr(input logic [1:0] s);
    logic [31:0] a;
    a = 32'h100 + 32'($urandom_range(0, 7)) * 4;
    if (s == 2'd0) a = a + 32'($urandom_range(0, 3));
    else if (s == 2'd1) a = a + 32'($urandom_range(0, 1)) * 2;
    return a;
  endfunction

  initial begin
    logic [1:0] s;
    int ci;
    vectors = 0; miscompares = 0; rob_ctr = '0;
    reset_model();
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_full", full, 1'b0);
    check("rst_we", bus_we, 1'b0);
    check("rst_re", bus_re, 1'b0);
    check("rst_ready", ld_ready, 1'b0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_feedback", feedback, 32'h0);
    @(negedge clk);
    rst = 0;

    // Single store: push, commit, drain.
    clear_inputs(); bus_ready = 1; drive_push(7'd3, 32'h100, 2'b10, 32'hDEAD_BEEF); cycle();
    clear_inputs(); bus_ready = 1; commit_valid = 1; commit_rob = 7'd3; cycle();
    clear_inputs(); bus_ready = 1; cycle();
    #1;
    check("sw_we", bus_we, 1'b1);
    check("sw_addr", bus_addr, 32'h100);
    check("sw_data", bus_wdata, 32'hDEAD_BEEF);
    cycle();
    repeat (2) cycle();

    // Fill to DEPTH, 17th push refused, then drain one.
    for (int i = 0; i < DEPTH; i++) begin
      clear_inputs(); drive_push(7'(10 + i), 32'h300 + 32'(i) * 4, 2'b10, $urandom); cycle();
    end
    clear_inputs(); drive_push(7'd99, 32'h380, 2'b10, 32'h1234_5678);
    #1;
    check("full_at_depth", full, 1'b1);
    cycle();
    clear_inputs(); bus_ready = 1; commit_valid = 1; commit_rob = 7'd10; cycle();
    clear_inputs(); bus_ready = 1;
    repeat (4) cycle();
    clear_inputs(); flush = 1; cycle();
    clear_inputs(); repeat (2) cycle();

    // Flush keeps committed rob 1, discards rob 2.
    clear_inputs(); drive_push(7'd1, 32'h140, 2'b10, 32'hAAAA_0001); cycle();
    clear_inputs(); drive_push(7'd2, 32'h144, 2'b10, 32'hBBBB_0002); cycle();
    clear_inputs(); commit_valid = 1; commit_rob = 7'd1; cycle();
    clear_inputs(); flush = 1; cycle();
    clear_inputs(); bus_ready = 1; repeat (5) cycle();

    // Forward and stall.
    clear_inputs(); drive_push(7'd30, 32'h200, 2'b10, 32'h1122_3344); cycle();
    clear_inputs(); bus_ready = 1; read_req = 1; read_addr = 32'h200; read_size = 2'b00;
    #1;
    check("fwd_data", feedback, 32'h44);
    check("fwd_ready", ld_ready, 1'b1);
    check("fwd_re", bus_re, 1'b0);
    cycle();
    clear_inputs(); bus_ready = 1; read_req = 1; read_addr = 32'h202; read_size = 2'b01;
    #1;
    check("stall_ready", ld_ready, 1'b0);
    check("stall_re", bus_re, 1'b0);
    cycle();
    clear_inputs(); flush = 1; cycle();

    // Starvation: drain wins on its 5th WRITE cycle against continuous loads.
    clear_inputs(); bus_ready = 1; drive_push(7'd20, 32'h500, 2'b10, 32'hCAFE_F00D); cycle();
    clear_inputs(); bus_ready = 1; bus_rdata = 32'h8765_4321;
    read_req = 1; read_addr = 32'h400; read_size = 2'b10;
    commit_valid = 1; commit_rob = 7'd20; cycle();
    commit_valid = 0; cycle();
    for (int k = 1; k <= 6; k++) begin
      #1;
      check("starve_we", bus_we, k == 5);
      check("starve_ready", ld_ready, k != 5);
      cycle();
    end

    // Reset while a drain is stuck in WRITE.
    clear_inputs(); drive_push(7'd40, 32'h600, 2'b10, 32'h0BAD_CAFE); cycle();
    clear_inputs(); commit_valid = 1; commit_rob = 7'd40; cycle();
    clear_inputs(); repeat (3) cycle();
    #1;
    check("pre_rst_we", bus_we, 1'b1);
    rst = 1;
    #1;
    check("rst_mid_we", bus_we, 1'b0);
    check("rst_mid_full", full, 1'b0);
    reset_model();
    @(negedge clk);
    rst = 0;
    clear_inputs(); bus_ready = 1; repeat (4) cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      clear_inputs();
      bus_ready = ($urandom_range(0, 9) < 7);
      bus_rdata = $urandom;
      if ($urandom_range(0, 9) < 5) begin
        s = 2'($urandom_range(0, 2));
        drive_push(rob_ctr, rand_addr(s), s, $urandom);
        rob_ctr = rob_ctr + 7'd1;
      end
      if ($urandom_range(0, 9) < 5) begin
        read_req  = 1;
        read_size = 2'($urandom_range(0, 2));
        read_addr = rand_addr(read_size);
      end
      if ($urandom_range(0, 9) < 4) begin
        commit_valid = 1;
        ci = 0;
        while (ci < sb.size() && sb[ci].committed) ci++;
        commit_rob = (ci < sb.size() && $urandom_range(0, 9) < 8) ? sb[ci].rob : 7'($urandom);
      end
      flush = ($urandom_range(0, 99) < 4);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
